nmi_bus_guard: RTL
==================

// Module: nmi_bus_guard
// PURPOSE
//  Registered NMI slice with bus-timeout watchdog. It sits directly downstream of
//  core_wrapper's nmi master, and upstream of the address decode/interconnect.
//  It re-issues each core request one cycle later and waits for the slave's ready.
//  If no slave answers within TIMEOUT_CYCLES, it completes the core access with
//  ERR_RDATA and logs the fault, so a bad address never hangs the core.
// PARAMETERS
//  TIMEOUT_CYCLES  1024           max cycles m_valid_o waits for m_ready_i; 0 = no timeout
//  ERR_RDATA       32'hDEAD_BEEF  rdata returned to core on timeout
//  CNT_WIDTH       8              width of saturating fault counter
// PORTS
//  clk_i        in   1          clock
//  rst_n_i      in   1          async reset, active low
//  s_valid_i    in   1          core request valid (held until s_ready_o)
//  s_addr_i     in   32         core address
//  s_wdata_i    in   32         core write data
//  s_wstrb_i    in   4          byte strobes; 0 = read
//  s_rdata_o    out  32         read data to core, valid with s_ready_o
//  s_ready_o    out  1          one-cycle completion pulse to core
//  m_valid_o    out  1          request valid to interconnect
//  m_addr_o     out  32         registered address
//  m_wdata_o    out  32         registered write data
//  m_wstrb_o    out  4          registered strobes
//  m_rdata_i    in   32         slave read data, sampled with m_ready_i
//  m_ready_i    in   1          slave completion
//  err_clr_i    in   1          pulse: clear err_o
//  err_o        out  1          sticky: timeout has occurred
//  err_addr_o   out  32         address of the most recent timed-out access
//  err_cnt_o    out  CNT_WIDTH  timeout count, saturates at all-ones, cleared only by reset
//  irq_o        out  1          timeout interrupt pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wait counter 0. Reset is asynchronous, so it aborts any
//   in-flight access; m_valid_o drops immediately.
//  FSM:
//   IDLE: if s_valid_i -> capture addr/wdata/wstrb, clear wait counter -> REQ.
//   REQ:  m_valid_o=1 with registered fields held stable.
//         m_ready_i=1 -> latch m_rdata_i -> RESP.
//         Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 -> latch
//         ERR_RDATA; set err_o; err_addr_o<=m_addr_o; err_cnt_o++ (saturating) -> RESP.
//         Otherwise counter++.
//   RESP: s_ready_o=1 and s_rdata_o=latched data for exactly 1 cycle -> IDLE.
//  Timing: core valid sampled at edge N -> m_valid_o high from N+1.
//   m_ready_i sampled at edge K -> s_ready_o high in cycle K+1.
//   Minimum s_valid_i-to-s_ready_o latency is 2 cycles.
//   Timeout: m_valid_o is high for exactly TIMEOUT_CYCLES cycles, then s_ready_o follows.
//  s_rdata_o holds its last value outside RESP. Write data is never returned.
//  m_ready_i arriving in the same cycle the timeout would fire: ready wins, no fault logged.
//  m_ready_i arriving outside REQ (late slave) is ignored.
//  err_clr_i coinciding with a timeout: set wins, err_o stays 1.
//  At most one outstanding access; s_valid_i during REQ/RESP is not re-sampled.
//  The core drops or renews valid at the ready edge, so IDLE treats s_valid_i as a new request.
// CONFIGURATION
//  NMI_GUARD_IRQ_EN defined: irq_o pulses 1 for one cycle, in the cycle after each timeout
//   transition, aligned with s_ready_o.
//  NMI_GUARD_IRQ_EN undefined: irq_o tied 0 and no IRQ logic is built. The port still exists.
// TESTING
//  1 Read, slave ready 3 cycles after m_valid_o: addr 0x0300_0010, m_rdata 0x1234_5678
//    -> s_rdata_o=0x1234_5678 with s_ready_o 1 cycle after m_ready_i; err_o=0.
//  2 Write, wstrb 4'b0011, wdata 0xA5A5_0F0F, ready in first REQ cycle
//    -> m_* fields match, s_ready_o 2 cycles after s_valid_i.
//  3 TIMEOUT_CYCLES=16, no ready: addr 0x7000_0000 -> m_valid_o high 16 cycles; s_rdata_o=0xDEAD_BEEF;
//    err_o=1; err_addr_o=0x7000_0000; err_cnt_o=1; irq_o pulse iff NMI_GUARD_IRQ_EN.
//  4 m_ready_i on the exact timeout cycle -> slave data returned; err_cnt_o unchanged.
//    Then 256 timeouts -> err_cnt_o stays 8'hFF; err_clr_i + timeout same cycle -> err_o=1.
//  5 Assert rst_n_i low mid-REQ -> m_valid_o/s_ready_o 0 asynchronously; after release,
//    a back-to-back request sequence completes normally.
//  6 Stray m_ready_i pulse in IDLE -> no s_ready_o, no state change.

Source files
------------

// File: rtl/nmi_bus_guard.sv
// nmi_bus_guard
//   Registered NMI slice with a bus-timeout watchdog. It sits between the core's
//   nmi master and the address decode. Each core request is re-issued one cycle
//   later on the m_* side. If no slave answers within TIMEOUT_CYCLES, the core
//   access completes with ERR_RDATA and the fault is logged, so a bad address
//   can never hang the core.
//
//   Handshake: the core holds s_valid_i and its fields until a one-cycle
//   s_ready_o pulse. m_valid_o stays high, with its fields stable, until the
//   slave answers with m_ready_i or the watchdog expires. Only one access is
//   outstanding at any time. m_ready_i is ignored unless a request is pending.
//
// Parameters
//   TIMEOUT_CYCLES  cycles m_valid_o may wait for m_ready_i (0 = never time out)
//   ERR_RDATA       read data returned to the core on timeout
//   CNT_WIDTH       width of the saturating timeout counter
//
// Ports
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   s_valid_i/s_addr_i/s_wdata_i/s_wstrb_i   core request (wstrb 0 = read)
//   s_rdata_o, s_ready_o       core completion (ready is a one-cycle pulse)
//   m_valid_o/m_addr_o/m_wdata_o/m_wstrb_o   registered request to interconnect
//   m_rdata_i, m_ready_i       slave completion
//   err_clr_i                  clears err_o (a timeout in the same cycle wins)
//   err_o, err_addr_o, err_cnt_o  sticky flag, last faulting address, count
//   irq_o                      one-cycle timeout interrupt, aligned with s_ready_o
//   dbg_state_o                current FSM state (IDLE=0, REQ=1, RESP=2)
//
// Build option
//   NMI_GUARD_IRQ_EN  when defined, irq_o pulses on each timeout; otherwise
//                     irq_o is tied low and no interrupt logic is built.

module nmi_bus_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 s_valid_i,
  input  logic [31:0]          s_addr_i,
  input  logic [31:0]          s_wdata_i,
  input  logic [3:0]           s_wstrb_i,
  output logic [31:0]          s_rdata_o,
  output logic                 s_ready_o,
  output logic                 m_valid_o,
  output logic [31:0]          m_addr_o,
  output logic [31:0]          m_wdata_o,
  output logic [3:0]           m_wstrb_o,
  input  logic [31:0]          m_rdata_i,
  input  logic                 m_ready_i,
  input  logic                 err_clr_i,
  output logic                 err_o,
  output logic [31:0]          err_addr_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 irq_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_fire;

  // A slave answer in the last allowed cycle beats the watchdog.
  assign timeout_fire = TIMEOUT_EN && (state == REQ) && !m_ready_i &&
                        (wait_cnt == WAIT_LAST);

  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      m_valid_o  <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      m_wstrb_o  <= '0;
      s_ready_o  <= 1'b0;
      s_rdata_o  <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid_i) begin
            m_addr_o  <= s_addr_i;
            m_wdata_o <= s_wdata_i;
            m_wstrb_o <= s_wstrb_i;
            wait_cnt  <= '0;
            m_valid_o <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (m_ready_i) begin
            s_rdata_o <= m_rdata_i;
            m_valid_o <= 1'b0;
            s_ready_o <= 1'b1;
            state     <= RESP;
          end else if (timeout_fire) begin
            s_rdata_o  <= ERR_RDATA;
            err_addr_o <= m_addr_o;
            if (err_cnt_o != {CNT_WIDTH{1'b1}}) begin
              err_cnt_o <= err_cnt_o + 1'b1;
            end
            m_valid_o  <= 1'b0;
            s_ready_o  <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          // s_rdata_o keeps the returned value after the pulse.
          s_ready_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          m_valid_o <= 1'b0;
          s_ready_o <= 1'b0;
          state     <= IDLE;
        end
      endcase

      // Set has priority over clear so a coincident timeout is never lost.
      if (timeout_fire) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

`ifdef NMI_GUARD_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= timeout_fire;
    end
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule
